theta_stage: RTL

Column-parity (theta) stage of the matrix encoder permutation, sitting directly upstream of the rotate stage. It reads the 5x5 lane state from the shared state memory and computes the five column parities. It then writes every lane back XORed with its column's theta value. Its one-cycle `done` pulse drives the rotate stage's `rotate_en`.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/lane_counter.sv | 56 +++++
 rtl/theta_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the matrix encoder permutation stages.
package encoder_pkg;

  localparam int W      = 64;
  localparam int NLANES = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAR_ADDR = 3'd1,
    ST_PAR_ACC  = 3'd2,
    ST_DCALC    = 3'd3,
    ST_UPD_ADDR = 3'd4,
    ST_UPD_WR   = 3'd5,
    ST_DONE     = 3'd6
  } theta_state_e;

  // Flat lane index 5*y+x for the 5x5 lane array.
  function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
    return ({2'b00, y} * 5'd5) + {2'b00, x};
  endfunction

  // Rotate left by one; the MSB wraps into bit 0.
  function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1]};
  endfunction

endpackage

// File: rtl/lane_counter.sv
// Nested mod-5 lane counters (x fastest, then y) with end-of-array carry.
module lane_counter
  import encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       co
);

  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;

  // Next-count logic: clear wins, otherwise step x and ripple into y on wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = 3'd0;
      y_d = 3'd0;
    end else if (en) begin
      if (x_q == 3'd4) begin
        x_d = 3'd0;
        if (y_q == 3'd4) begin
          y_d = 3'd0;
        end else begin
          y_d = y_q + 3'd1;
        end
      end else begin
        x_d = x_q + 3'd1;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 3'd0;
      y_q <= 3'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x  = x_q;
  assign y  = y_q;
  assign co = en & (x_q == 3'd4) & (y_q == 3'd4);

endmodule

// File: rtl/theta_stage.sv
// Theta stage: accumulate column parities, derive D[x], rewrite every lane.
module theta_stage
  import encoder_pkg::*;
#(
  parameter int W = encoder_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [4:0]   mem_rd_addr,
  input  logic [W-1:0] mem_rd_data,
  output logic         mem_wr_en,
  output logic [4:0]   mem_wr_addr,
  output logic [W-1:0] mem_wr_data,
  output logic         busy,
  output logic         done
);

  theta_state_e state_q, state_d;

  logic [W-1:0] c_q [5];
  logic [W-1:0] c_d [5];
  logic [W-1:0] d_q [5];
  logic [W-1:0] d_d [5];

  logic [2:0] x_s, y_s;
  logic       cnt_en_s, cnt_clr_s, co_s;

  // One counter pair serves both the parity and the update sweeps.
  assign cnt_en_s  = (state_q == ST_PAR_ACC) || (state_q == ST_UPD_WR);
  assign cnt_clr_s = (state_q == ST_IDLE);

  lane_counter u_lane_counter (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en_s),
    .clr (cnt_clr_s),
    .x   (x_s),
    .y   (y_s),
    .co  (co_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start ? ST_PAR_ADDR : ST_IDLE;
      ST_PAR_ADDR: state_d = ST_PAR_ACC;
      ST_PAR_ACC:  state_d = co_s ? ST_DCALC : ST_PAR_ADDR;
      ST_DCALC:    state_d = ST_UPD_ADDR;
      ST_UPD_ADDR: state_d = ST_UPD_WR;
      ST_UPD_WR:   state_d = co_s ? ST_DONE : ST_UPD_ADDR;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Parity and theta datapath next values.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      c_d[i] = c_q[i];
      d_d[i] = d_q[i];
    end
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < 5; i++) begin
        c_d[i] = '0;
      end
    end else if (state_q == ST_PAR_ACC) begin
      c_d[x_s] = c_q[x_s] ^ mem_rd_data;
    end else if (state_q == ST_DCALC) begin
      for (int i = 0; i < 5; i++) begin
        d_d[i] = c_q[(i + 4) % 5] ^ rotl1(c_q[(i + 1) % 5]);
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        c_d[i] = c_q[i];
      end
    end
  end

  // Parity (C) and theta (D) registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        c_q[i] <= c_d[i];
        d_q[i] <= d_d[i];
      end
    end
  end

  // Output decode from state and counters; write data merges the read lane.
  always_comb begin
    mem_rd_addr = 5'd0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = 5'd0;
    mem_wr_data = '0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    case (state_q)
      ST_PAR_ADDR, ST_UPD_ADDR: mem_rd_addr = lane_idx(x_s, y_s);
      ST_UPD_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = lane_idx(x_s, y_s);
        mem_wr_data = mem_rd_data ^ d_q[x_s];
      end
      ST_DONE:   done = 1'b1;
      default:   mem_rd_addr = 5'd0;
    endcase
  end

endmodule
